// File: rtl/inst_fetch_if.sv
// Instruction-fetch bus bundle.
// Purpose: groups the ROM port, decode-side handshake and redirect inputs of
//          the fetch stage so they can be passed as a single port.
// Signals:
//   pc_o            fetch address to the instruction ROM
//   ce_o            ROM fetch enable
//   inst_i          ROM data for pc_o (combinational, same cycle)
//   stall_i         decode cannot accept an instruction this cycle
//   branch_flag_i   single-cycle redirect request
//   branch_target_i redirect address, qualified by branch_flag_i
//   if_pc_o         PC presented to decode
//   if_inst_o       instruction presented to decode
//   if_valid_o      if_pc_o/if_inst_o valid
//   exc_misalign_o  sticky misaligned-redirect flag
// Modports: master = fetch stage, slave = ROM/decode/redirect side.
interface inst_fetch_if;
  logic [31:0] pc_o;
  logic        ce_o;
  logic [31:0] inst_i;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;
  logic        exc_misalign_o;

  modport master (
    output pc_o, ce_o, if_pc_o, if_inst_o, if_valid_o, exc_misalign_o,
    input  inst_i, stall_i, branch_flag_i, branch_target_i
  );

  modport slave (
    input  pc_o, ce_o, if_pc_o, if_inst_o, if_valid_o, exc_misalign_o,
    output inst_i, stall_i, branch_flag_i, branch_target_i
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage with a 2-entry {pc, inst} buffer toward decode.
// Purpose: walks pc_o through the instruction ROM, captures each ROM word into
//          a small FIFO and presents the head to decode; a redirect flushes
//          the FIFO and restarts fetching at the target.
// Ports:
//   clk  single clock, rising-edge
//   rst  asynchronous active-low reset
//   bus  inst_fetch_if.master (ROM port, decode handshake, redirect)
// Parameter: RESET_PC first fetch address after reset.
// Build option: define IF_ALIGN_CHECK_EN to trap redirects whose target is not
//   word aligned (flush, raise exc_misalign_o, stop fetching until reset).
//   Without it the low two target bits are dropped and exc_misalign_o is 0.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);

  logic [31:0] pc_q;
  logic        ce_q;
  logic        exc_q;
  logic [1:0]  cnt_q;
  logic [31:0] head_pc_q, head_inst_q;
  logic [31:0] tail_pc_q, tail_inst_q;

  logic        pop;
  logic        push;
  logic        misalign;
  logic [31:0] redirect_pc;

`ifdef IF_ALIGN_CHECK_EN
  assign misalign    = bus.branch_target_i[1:0] != 2'b00;
  assign redirect_pc = bus.branch_target_i;
`else
  assign misalign    = 1'b0;
  assign redirect_pc = {bus.branch_target_i[31:2], 2'b00};
`endif

  assign bus.if_valid_o     = cnt_q != 2'd0;
  assign bus.if_pc_o        = head_pc_q;
  assign bus.if_inst_o      = head_inst_q;
  assign bus.pc_o           = pc_q;
  assign bus.ce_o           = ce_q;
  assign bus.exc_misalign_o = exc_q;

  assign pop  = bus.if_valid_o & ~bus.stall_i;
  // A full FIFO still accepts a push when the head leaves in the same cycle;
  // otherwise the ROM read is simply repeated next cycle.
  assign push = ce_q & ~bus.branch_flag_i & ((cnt_q != 2'd2) | pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_PC;
      ce_q        <= 1'b0;
      exc_q       <= 1'b0;
      cnt_q       <= 2'd0;
      head_pc_q   <= 32'd0;
      head_inst_q <= 32'd0;
      tail_pc_q   <= 32'd0;
      tail_inst_q <= 32'd0;
    end else begin
      // Fetch is enabled from the first edge after reset and only ever
      // dropped by a trapped misaligned redirect.
      ce_q <= ~exc_q & ~(bus.branch_flag_i & misalign);
      if (bus.branch_flag_i) begin
        // Any entry popped this cycle has already been taken by decode.
        cnt_q <= 2'd0;
        pc_q  <= redirect_pc;
        if (misalign) exc_q <= 1'b1;
      end else begin
        if (push) pc_q <= pc_q + 32'd4;
        case ({push, pop})
          2'b11: begin
            if (cnt_q == 2'd2) begin
              head_pc_q   <= tail_pc_q;
              head_inst_q <= tail_inst_q;
              tail_pc_q   <= pc_q;
              tail_inst_q <= bus.inst_i;
            end else begin
              head_pc_q   <= pc_q;
              head_inst_q <= bus.inst_i;
            end
          end
          2'b10: begin
            if (cnt_q == 2'd0) begin
              head_pc_q   <= pc_q;
              head_inst_q <= bus.inst_i;
            end else begin
              tail_pc_q   <= pc_q;
              tail_inst_q <= bus.inst_i;
            end
            cnt_q <= cnt_q + 2'd1;
          end
          2'b01: begin
            head_pc_q   <= tail_pc_q;
            head_inst_q <= tail_inst_q;
            cnt_q       <= cnt_q - 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IF_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  inst_fetch_if bus();

  inst_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Instruction ROM: word at address a is a + 0x1000.
  assign bus.inst_i = bus.pc_o + 32'h1000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: queue of delivered-in-order {pc, inst} entries.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc  = RESET_PC;
  bit          m_ce  = 1'b0;
  bit          m_exc = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mq.delete();
        m_pc  = RESET_PC;
        m_ce  = 1'b0;
        m_exc = 1'b0;
      end else begin
        if (mq.size() != 0 && !bus.stall_i) void'(mq.pop_front());
        if (bus.branch_flag_i) begin
          mq.delete();
          if (ALIGN_EN && bus.branch_target_i[1:0] != 2'b00) begin
            m_exc = 1'b1;
            m_pc  = bus.branch_target_i;
          end else begin
            m_pc = bus.branch_target_i & 32'hFFFF_FFFC;
          end
        end else if (m_ce && mq.size() < 2) begin
          mq.push_back({m_pc, m_pc + 32'h1000});
          m_pc = m_pc + 32'd4;
        end
        m_ce = !m_exc;
      end
      #1;
      chk("model_pc_o", bus.pc_o, m_pc);
      chk("model_ce_o", {31'd0, bus.ce_o}, {31'd0, m_ce});
      chk("model_if_valid_o", {31'd0, bus.if_valid_o}, {31'd0, mq.size() != 0});
      chk("model_exc_misalign_o", {31'd0, bus.exc_misalign_o}, {31'd0, m_exc});
      if (mq.size() != 0) begin
        chk("model_if_pc_o", bus.if_pc_o, mq[0].pc);
        chk("model_if_inst_o", bus.if_inst_o, mq[0].inst);
      end
      if (!rst) begin
        chk("model_rst_if_pc_o", bus.if_pc_o, 32'd0);
        chk("model_rst_if_inst_o", bus.if_inst_o, 32'd0);
      end
    end
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc_o"}, bus.pc_o, RESET_PC);
    chk({tag, "_ce_o"}, {31'd0, bus.ce_o}, 32'd0);
    chk({tag, "_if_valid_o"}, {31'd0, bus.if_valid_o}, 32'd0);
    chk({tag, "_if_pc_o"}, bus.if_pc_o, 32'd0);
    chk({tag, "_if_inst_o"}, bus.if_inst_o, 32'd0);
    chk({tag, "_exc"}, {31'd0, bus.exc_misalign_o}, 32'd0);
  endtask

  initial begin
    logic [31:0] tgt;
    bus.stall_i         = 1'b0;
    bus.branch_flag_i   = 1'b0;
    bus.branch_target_i = 32'd0;

    // Reset held, then release and watch the start-up sequence.
    repeat (2) @(negedge clk);
    #1 chk_reset_vals("reset");
    @(negedge clk) rst = 1'b1;
    edge1();
    chk("start_e1_ce", {31'd0, bus.ce_o}, 32'd1);
    chk("start_e1_valid", {31'd0, bus.if_valid_o}, 32'd0);
    edge1();
    chk("start_e2_valid", {31'd0, bus.if_valid_o}, 32'd1);
    chk("start_e2_pc", bus.if_pc_o, 32'h0);
    chk("start_e2_inst", bus.if_inst_o, 32'h1000);
    for (int k = 1; k <= 3; k++) begin
      edge1();
      chk("stream_pc", bus.if_pc_o, 32'(4 * k));
    end
    chk("stream_fetch_pc", bus.pc_o, 32'd16);

    // Five stalled cycles: FIFO fills, fetch address freezes.
    @(negedge clk) bus.stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      edge1();
      chk("stall_if_pc", bus.if_pc_o, 32'd12);
      chk("stall_pc_o", bus.pc_o, 32'd20);
    end
    @(negedge clk) bus.stall_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      edge1();
      chk("unstall_pc", bus.if_pc_o, 32'(16 + 4 * k));
    end

    // Redirect to 0x40 while stalled with a full FIFO.
    @(negedge clk) bus.stall_i = 1'b1;
    edge1();
    @(negedge clk) begin
      bus.branch_flag_i   = 1'b1;
      bus.branch_target_i = 32'h40;
    end
    edge1();
    chk("br40_valid", {31'd0, bus.if_valid_o}, 32'd0);
    chk("br40_pc_o", bus.pc_o, 32'h40);
    @(negedge clk) begin
      bus.branch_flag_i = 1'b0;
      bus.stall_i       = 1'b0;
    end
    edge1();
    chk("br40_if_pc", bus.if_pc_o, 32'h40);
    chk("br40_if_inst", bus.if_inst_o, 32'h1040);

    // Redirect close to the top of the address space: wrap to zero.
    @(negedge clk) begin
      bus.branch_flag_i   = 1'b1;
      bus.branch_target_i = 32'hFFFF_FFF8;
    end
    edge1();
    @(negedge clk) bus.branch_flag_i = 1'b0;
    edge1();
    chk("wrap_pc0", bus.if_pc_o, 32'hFFFF_FFF8);
    edge1();
    chk("wrap_pc1", bus.if_pc_o, 32'hFFFF_FFFC);
    edge1();
    chk("wrap_pc2", bus.if_pc_o, 32'h0000_0000);
    chk("wrap_inst2", bus.if_inst_o, 32'h0000_1000);

    // Short reset pulse with a full FIFO.
    @(negedge clk) bus.stall_i = 1'b1;
    repeat (2) edge1();
    @(negedge clk);
    #1 rst = 1'b0;
    bus.stall_i = 1'b0;
    #1 chk_reset_vals("rstpulse");
    #2 rst = 1'b1;
    edge1();
    chk("restart_e1_ce", {31'd0, bus.ce_o}, 32'd1);
    chk("restart_e1_valid", {31'd0, bus.if_valid_o}, 32'd0);
    edge1();
    chk("restart_e2_pc", bus.if_pc_o, RESET_PC);
    chk("restart_e2_valid", {31'd0, bus.if_valid_o}, 32'd1);

    // Misaligned redirect target.
    @(negedge clk) begin
      bus.branch_flag_i   = 1'b1;
      bus.branch_target_i = 32'h42;
    end
    edge1();
    @(negedge clk) bus.branch_flag_i = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
    chk("misal_exc", {31'd0, bus.exc_misalign_o}, 32'd1);
    chk("misal_ce", {31'd0, bus.ce_o}, 32'd0);
    chk("misal_pc_o", bus.pc_o, 32'h42);
    for (int i = 0; i < 3; i++) begin
      edge1();
      chk("misal_hold_valid", {31'd0, bus.if_valid_o}, 32'd0);
      chk("misal_hold_ce", {31'd0, bus.ce_o}, 32'd0);
      chk("misal_hold_exc", {31'd0, bus.exc_misalign_o}, 32'd1);
    end
`else
    edge1();
    chk("misal_pc0", bus.if_pc_o, 32'h40);
    edge1();
    chk("misal_pc1", bus.if_pc_o, 32'h44);
    chk("misal_exc", {31'd0, bus.exc_misalign_o}, 32'd0);
`endif
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      bus.stall_i       = ($urandom_range(0, 99) < 40);
      bus.branch_flag_i = ($urandom_range(0, 15) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
      if (ALIGN_EN) tgt = tgt & 32'hFFFF_FFFC;
      bus.branch_target_i = tgt;
      if ($urandom_range(0, 299) == 0) begin
        #1 rst = 1'b0;
        @(negedge clk) rst = 1'b1;
      end
    end
    @(negedge clk) begin
      bus.stall_i       = 1'b0;
      bus.branch_flag_i = 1'b0;
    end
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
